// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one uarttx among N_REQ
// byte producers, with start-bit handshake, done_tx edge detect and timeout.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int GAP_CYCLES     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic               busy,
    output logic               uart_newd,
    output logic [7:0]         uart_data,
    input  logic               uart_tx,
    input  logic               uart_done_tx
);
    localparam int RW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_e;

    state_e           state_q;
    logic [RW-1:0]    rr_q;
    logic [RW-1:0]    win_q;
    logic [RW-1:0]    win_d;
    logic [RW-1:0]    rr_d;
    logic             found_d;
    logic [CW-1:0]    cnt_q;
    logic             dtx_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic             err_q;
    logic             newd_q;
    logic [7:0]       data_q;
    logic             tmo;
    logic             dtx_rise;

    assign tmo      = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign dtx_rise = uart_done_tx & ~dtx_q;

    // first requester at or above the rr pointer, wrapping around
    always_comb begin
        win_d   = '0;
        found_d = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = int'(rr_q) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found_d && req[j]) begin
                found_d = 1'b1;
                win_d   = RW'(j);
            end
        end
    end

    assign rr_d = (win_d == RW'(N_REQ - 1)) ? '0 : win_d + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            dtx_q   <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            newd_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            dtx_q  <= uart_done_tx;
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (found_d) begin
                        win_q        <= win_d;
                        rr_q         <= rr_d;
                        gnt_q[win_d] <= 1'b1;
                        newd_q       <= 1'b1;
                        data_q       <= req_data[8*win_d +: 8];
                        cnt_q        <= '0;
                        state_q      <= LAUNCH;
                    end
                end
                LAUNCH, WAIT_DONE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (tmo) begin
                        done_q[win_q] <= 1'b1;
                        err_q         <= 1'b1;
                        newd_q        <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else if (state_q == LAUNCH && !uart_tx) begin
                        newd_q  <= 1'b0;
                        state_q <= WAIT_DONE;
                    end else if (state_q == WAIT_DONE && dtx_rise) begin
                        done_q[win_q] <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(GAP_CYCLES - 1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
    assign uart_newd = newd_q;
    assign uart_data = data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random checks of uart_tx_arbiter
// against a deadline-based reference model and a behavioural uarttx.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int TMO = 64;
    localparam int GAP = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           err;
    logic           busy;
    logic           uart_newd;
    logic [7:0]     uart_data;
    logic           uart_tx;
    logic           uart_done_tx;

    uart_tx_arbiter #(
        .N_REQ(N),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .done(done),
        .err(err),
        .busy(busy),
        .uart_newd(uart_newd),
        .uart_data(uart_data),
        .uart_tx(uart_tx),
        .uart_done_tx(uart_done_tx)
    );

    always #5 clk = ~clk;

    // behavioural uarttx: 2-cycle launch delay, 4 clocks per bit
    int         u_st;
    int         u_cnt;
    int         u_k;
    logic [9:0] u_fr;
    logic       u_dtx;
    bit         u_nostart;
    bit         u_nodone;
    bit         u_hold;
    logic [7:0] q_bytes[$];

    assign uart_done_tx = u_dtx | u_hold;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_st    <= 0;
            u_cnt   <= 0;
            u_k     <= 0;
            u_fr    <= '0;
            uart_tx <= 1'b1;
            u_dtx   <= 1'b0;
        end else begin
            u_dtx <= 1'b0;
            case (u_st)
                0: if (uart_newd && !u_nostart) begin
                    u_fr  <= {1'b1, uart_data, 1'b0};
                    u_cnt <= 2;
                    u_st  <= 1;
                end
                1: if (u_cnt == 0) begin
                    uart_tx <= u_fr[0];
                    u_k     <= 0;
                    u_cnt   <= 3;
                    u_st    <= 2;
                end else u_cnt <= u_cnt - 1;
                2: if (u_cnt != 0) u_cnt <= u_cnt - 1;
                else if (u_k == 9) begin
                    uart_tx <= 1'b1;
                    u_st    <= 3;
                end else begin
                    uart_tx <= u_fr[u_k+1];
                    u_k     <= u_k + 1;
                    u_cnt   <= 3;
                end
                default: begin
                    if (!u_nodone) u_dtx <= 1'b1;
                    q_bytes.push_back(u_fr[8:1]);
                    u_st <= 0;
                end
            endcase
        end
    end

    int total = 0;
    int bad   = 0;

    // reference model: arbiter described by deadlines and a rotating pointer
    int         cyc = 0;
    int         m_rr = 0;
    int         m_win = 0;
    int         m_g = 0;
    int         m_free = 0;
    bit         m_launch = 0;
    bit         m_wait = 0;
    bit         m_dprev = 0;
    logic [7:0] m_data = 8'h00;
    bit         drop = 1;

    int         q_g[$];
    int         q_d[$];
    int         last_g = 0;
    int         last_d = 0;
    logic       last_err = 1'b0;
    logic [N-1:0] last_dv = '0;
    int         n_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    function automatic bit m_idle();
        return !(m_launch || m_wait) && (cyc >= m_free - 1);
    endfunction

    task automatic step();
        logic [N-1:0]   r;
        logic [8*N-1:0] d;
        logic           tx;
        logic           dt;
        logic [N-1:0]   eg;
        logic [N-1:0]   ed;
        logic           ee;
        @(negedge clk);
        r  = req;
        d  = req_data;
        tx = uart_tx;
        dt = uart_done_tx;
        @(posedge clk);
        #1;
        cyc++;
        eg = '0;
        ed = '0;
        ee = 1'b0;
        if (m_launch || m_wait) begin
            if (cyc - m_g == TMO) begin
                ed[m_win] = 1'b1;
                ee        = 1'b1;
                m_launch  = 0;
                m_wait    = 0;
                m_free    = cyc + GAP + 1;
            end else if (m_launch && !tx) begin
                m_launch = 0;
                m_wait   = 1;
            end else if (m_wait && dt && !m_dprev) begin
                ed[m_win] = 1'b1;
                m_wait    = 0;
                m_free    = cyc + GAP + 1;
            end
        end else if (cyc >= m_free && r != 0) begin
            m_win     = pick(r, m_rr);
            eg[m_win] = 1'b1;
            m_rr      = (m_win + 1) % N;
            m_g       = cyc;
            m_launch  = 1;
            m_data    = d[8*m_win +: 8];
        end
        m_dprev = dt;
        chk("gnt", gnt, eg);
        chk("done", done, ed);
        chk("err", err, ee);
        chk("newd", uart_newd, m_launch);
        chk("busy", busy, !m_idle());
        if (m_launch) chk("data", uart_data, m_data);
        if (gnt != 0) begin
            q_g.push_back(idx(gnt));
            last_g = cyc;
        end
        if (done != 0) begin
            q_d.push_back(idx(done));
            last_d   = cyc;
            last_err = err;
            last_dv  = done;
            n_done++;
        end
        if (drop) req = req & ~gnt;
    endtask

    task automatic run_until(input int what, input int budget, input string tag);
        int n;
        bit hit;
        n   = 0;
        hit = 0;
        while (!hit && n < budget) begin
            step();
            n++;
            case (what)
                0:       hit = (gnt != 0);
                1:       hit = (done != 0);
                default: hit = m_idle() && (req == 0);
            endcase
        end
        total++;
        assert (hit) else begin
            bad++;
            $error("FAIL %s no event within %0d cycles", tag, n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_newd", uart_newd, 0);
        chk("rst_data", uart_data, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b1;
        m_launch = 0;
        m_wait   = 0;
        m_rr     = 0;
        m_free   = 0;
        m_dprev  = 0;
    endtask

    task automatic timeout_case(input logic [N-1:0] r, input string tag);
        req = r;
        run_until(0, 20, {tag, "_gnt"});
        run_until(1, 120, {tag, "_done"});
        chk({tag, "_dist"}, last_d - last_g, TMO);
        chk({tag, "_err"}, last_err, 1);
        chk({tag, "_who"}, last_dv, r);
        run_until(2, 40, {tag, "_idle"});
    endtask

    initial begin
        int d0;
        int n1;
        int base;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        #2;
        do_reset();

        // contention: all four held, grants rotate
        drop = 0;
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'h10 + 8'(i);
        q_g.delete();
        q_d.delete();
        q_bytes.delete();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) run_until(0, 80, "cont_gnt_wait");
        req = '0;
        run_until(2, 120, "cont_idle");
        for (int k = 0; k < 5; k++) begin
            chk("cont_order", (k < q_g.size()) ? q_g[k] : -1, k % N);
            chk("cont_done", (k < q_d.size()) ? q_d[k] : -1, k % N);
            chk("cont_byte", (k < q_bytes.size()) ? q_bytes[k] : 8'hxx,
                8'h10 + 8'(k % N));
        end
        drop = 1;

        // single request from requester 2
        q_bytes.delete();
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        step();
        chk("single_gnt", gnt, 4'b0100);
        chk("single_newd", uart_newd, 1);
        run_until(2, 120, "single_idle");
        chk("single_nbytes", q_bytes.size(), 1);
        chk("single_byte", (q_bytes.size() > 0) ? q_bytes[0] : 8'hxx, 8'hA5);
        chk("single_done", last_dv, 4'b0100);
        chk("single_err", last_err, 0);

        // pointer wrap: rr=3, requesters 0 and 1 pending
        req_data[7:0]  = 8'h30;
        req_data[15:8] = 8'h31;
        q_g.delete();
        req = 4'b0011;
        step();
        chk("wrap_first", gnt, 4'b0001);
        run_until(2, 200, "wrap_idle");
        chk("wrap_second", (q_g.size() > 1) ? q_g[1] : -1, 1);

        // timeouts: no done_tx, stale done_tx level, no start bit
        u_nodone = 1;
        timeout_case(4'b0010, "tmo_nodone");
        u_nodone = 0;
        u_hold   = 1;
        repeat (3) step();
        timeout_case(4'b1000, "tmo_stale");
        u_hold = 0;
        repeat (3) step();
        u_nostart = 1;
        timeout_case(4'b0001, "tmo_nostart");
        u_nostart = 0;

        // reset in the middle of a frame
        req = 4'b0100;
        run_until(0, 20, "mid_gnt");
        repeat (10) step();
        chk("mid_waiting", busy, 1);
        do_reset();
        n_done = 0;
        repeat (60) step();
        chk("mid_no_done", n_done, 0);
        req = 4'b1111;
        step();
        chk("post_rst_gnt", gnt, 4'b0001);
        run_until(2, 400, "post_rst_idle");

        // withdrawal during a frame, then gap before next grant
        base = q_g.size();
        req  = 4'b0001;
        run_until(0, 20, "gap_gnt0");
        req[1] = 1'b1;
        repeat (5) step();
        req[1] = 1'b0;
        run_until(1, 100, "gap_done0");
        d0  = last_d;
        req = 4'b0100;
        run_until(0, 30, "gap_gnt2");
        chk("gap_min", (last_g - d0) >= GAP, 1);
        chk("gap_who", q_g[q_g.size()-1], 2);
        n1 = 0;
        for (int k = base; k < q_g.size(); k++) if (q_g[k] == 1) n1++;
        chk("withdrawn_unserved", n1, 0);
        run_until(2, 120, "gap_idle");

        // random traffic with occasional hung transmitter and withdrawals
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 5) == 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 39) == 0) begin
                    req[i] = 1'b0;
                end
            end
            if (m_idle()) u_nodone = ($urandom_range(0, 9) == 0);
            step();
        end
        req      = '0;
        u_nodone = 0;
        run_until(2, 200, "rand_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
